mdu_iter: RTL and testbench

- Parametrised iterative multiply/divide unit; the RV32M companion to the single-cycle integer ALU in the execute stage.
- Implements MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on WIDTH-bit operands using a radix-2 shift-add multiplier and a restoring divider, one bit per cycle.
- Uses a valid/ready handshake on both sides so the pipeline can stall on it. Supports an abort for pipeline flushes.

---
 rtl/mdu_iter.sv | 179 +++++++++++++++++
 tb/tb_mdu_iter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiplier and restoring
// divider sharing one 2*WIDTH accumulator, one bit per cycle, valid/ready on both sides.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
    return n ? ({WIDTH{1'b0}} - v) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? ({(2*WIDTH){1'b0}} - v) : v;
  endfunction

  state_t             state_r, state_s;
  logic [2:0]         op_r, op_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [2*WIDTH-1:0] acc_r, acc_s;
  logic [WIDTH-1:0]   opnd_r, opnd_s;
  logic [WIDTH-1:0]   res_r, res_s;
  logic               neg_r, neg_s;
  logic               rneg_r, rneg_s;

  logic               accept_s, signed_a_s, signed_b_s, a_neg_s, b_neg_s;
  logic               div_zero_s, ovf_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s, special_s;
  logic [WIDTH:0]     mul_sum_s, div_shift_s, div_diff_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   fix_s;

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign res       = res_r;

  assign accept_s   = in_valid && (state_r == IDLE) && !abort;
  assign signed_a_s = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
  assign signed_b_s = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
  assign a_neg_s    = signed_a_s && a[WIDTH-1];
  assign b_neg_s    = signed_b_s && b[WIDTH-1];
  assign mag_a_s    = cond_neg(a, a_neg_s);
  assign mag_b_s    = cond_neg(b, b_neg_s);
  assign div_zero_s = op[2] && (b == {WIDTH{1'b0}});
  assign ovf_s      = op[2] && !op[0] && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == {WIDTH{1'b1}});
  assign special_s  = div_zero_s ? (op[1] ? a : {WIDTH{1'b1}})
                                 : (op[1] ? {WIDTH{1'b0}} : a);

  // Multiply keeps {partial_hi, multiplier}; divide keeps {remainder, quotient/dividend}
  assign mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                       (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
  assign div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
  assign div_diff_s  = div_shift_s - {1'b0, opnd_r};
  assign prod_s      = cond_neg2(acc_r, neg_r);

  // Sign correction and result select for the FIX cycle
  always_comb begin
    fix_s = {WIDTH{1'b0}};
    if (!op_r[2]) begin
      fix_s = (op_r == 3'd0) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
    end else if (!op_r[1]) begin
      fix_s = cond_neg(acc_r[WIDTH-1:0], neg_r);
    end else begin
      fix_s = cond_neg(acc_r[2*WIDTH-1:WIDTH], rneg_r);
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_s = state_r;
    op_s    = op_r;
    cnt_s   = cnt_r;
    acc_s   = acc_r;
    opnd_s  = opnd_r;
    res_s   = res_r;
    neg_s   = neg_r;
    rneg_s  = rneg_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          op_s  = op;
          cnt_s = {CNT_W{1'b0}};
          if (div_zero_s || ovf_s) begin
            res_s   = special_s;
            state_s = DONE;
          end else begin
            state_s = CALC;
            neg_s   = a_neg_s ^ b_neg_s;
            rneg_s  = a_neg_s;
            if (op[2]) begin
              acc_s  = {{WIDTH{1'b0}}, mag_a_s};
              opnd_s = mag_b_s;
            end else begin
              acc_s  = {{WIDTH{1'b0}}, mag_b_s};
              opnd_s = mag_a_s;
            end
          end
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (abort) begin
          state_s = IDLE;
        end else begin
          if (!op_r[2]) begin
            acc_s = {mul_sum_s, acc_r[WIDTH-1:1]};
          end else if (!div_diff_s[WIDTH]) begin
            acc_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
          end else begin
            acc_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
          end
          cnt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          state_s = (cnt_r == CNT_W'(WIDTH - 1)) ? FIX : CALC;
        end
      end
      FIX: begin
        if (abort) begin
          state_s = IDLE;
        end else begin
          res_s   = fix_s;
          state_s = DONE;
        end
      end
      DONE: begin
        if (abort || out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      op_r    <= 3'd0;
      cnt_r   <= {CNT_W{1'b0}};
      acc_r   <= {(2*WIDTH){1'b0}};
      opnd_r  <= {WIDTH{1'b0}};
      res_r   <= {WIDTH{1'b0}};
      neg_r   <= 1'b0;
      rneg_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      op_r    <= op_s;
      cnt_r   <= cnt_s;
      acc_r   <= acc_s;
      opnd_r  <= opnd_s;
      res_r   <= res_s;
      neg_r   <= neg_s;
      rneg_r  <= rneg_s;
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed cases plus random ops compared against
// a plain-arithmetic RV32M reference model.
module tb_mdu_iter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = 32'd0;
  logic [W-1:0] b = 32'd0;
  logic         abort = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] res;

  int checks = 0;
  int errors = 0;

  mdu_iter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready), .res(res)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, uy_s, p;
    logic [63:0] ux, uy, up;
    logic signed [31:0] qx, qy;
    logic ovf;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'd0, x};
    uy = {32'd0, y};
    uy_s = uy;
    qx = x;
    qy = y;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin up = ux * uy; return up[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy_s; return p[63:32]; end
      3'd3: begin up = ux * uy; return up[63:32]; end
      3'd4: return (y == 32'd0) ? 32'hFFFF_FFFF : (ovf ? x : 32'(qx / qy));
      3'd5: return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
      3'd6: return (y == 32'd0) ? x : (ovf ? 32'd0 : 32'(qx % qy));
      default: return (y == 32'd0) ? x : x % y;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, wait for its result, check value and latency, then complete the handshake.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
    logic [31:0] exp;
    bit special;
    int lat;
    exp = ref_model(o, x, y);
    special = (o[2] && y == 32'd0) ||
              ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
    @(negedge clk);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom); a = $urandom; b = $urandom;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_res"}, res, exp);
    check({tag, "_latency"}, 32'(lat), special ? 32'd1 : 32'd34);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_release"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] held, ra, rb;
    logic [2:0] ro;
    int n;

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {30'd0, in_ready, out_valid}, 32'd2);
    check("reset_res", res, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem");
    run_op(3'd5, 32'd100, 32'd7, "divu");
    run_op(3'd7, 32'd100, 32'd7, "remu");
    run_op(3'd5, 32'd100, 32'd0, "divu_zero");
    run_op(3'd7, 32'd100, 32'd0, "remu_zero");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    run_op(3'd4, 32'h0000_0005, 32'd0, "div_zero");
    run_op(3'd6, 32'hFFFF_FFF0, 32'd0, "rem_zero");

    // Reset in the middle of a DIV
    @(negedge clk);
    op = 3'd4; a = 32'd1000; b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_state", {30'd0, in_ready, out_valid}, 32'd2);
    check("midreset_res", res, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(3'd0, 32'd3, 32'd5, "mul_after_reset");

    // Backpressure: result must hold while out_ready is low
    @(negedge clk);
    op = 3'd4; a = 32'hFFFF_FF00; b = 32'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    held = ref_model(3'd4, 32'hFFFF_FF00, 32'd9);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("bp_state", {30'd0, in_ready, out_valid}, 32'd1);
      check("bp_res", res, held);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release", {30'd0, out_valid, in_ready}, 32'd1);

    // Abort in cycle 5 of MULHU: the op must never complete
    @(negedge clk);
    op = 3'd3; a = 32'hDEAD_BEEF; b = 32'h1234_5678; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_calc_idle", {31'd0, in_ready}, 32'd1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    check("abort_calc_no_result", 32'(n), 32'd0);

    // Abort together with a request in IDLE drops the request
    @(negedge clk);
    op = 3'd5; a = 32'd50; b = 32'd5; in_valid = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; abort = 1'b0;
    check("abort_idle_ready", {31'd0, in_ready}, 32'd1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    check("abort_idle_no_result", 32'(n), 32'd0);
    run_op(3'd5, 32'd9, 32'd3, "divu_after_abort");

    // Abort while a result is waiting in DONE
    @(negedge clk);
    op = 3'd7; a = 32'd17; b = 32'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("abort_done_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_done_drop", {30'd0, out_valid, in_ready}, 32'd1);

    // Random operations with a bias towards boundary operands
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(ro, ra, rb, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
